// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared state encoding and result record for the adder
//               result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              zero;
        logic              neg;
        logic              ovf;
    } res_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/adder_flags.sv
// ============================================================================
// Module      : adder_flags
// Description : Combinational status-flag derivation for one adder result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_flags
    import adder_pkg::*;
(
    input  logic [DATA_W-1:0] i_sum,
    input  logic              i_cout,
    input  logic              i_a_msb,
    input  logic              i_b_msb,
    output res_t              o_res
);

    // Overflow: operands share a sign that the sum does not.
    always_comb begin
        o_res.sum  = i_sum;
        o_res.cout = i_cout;
        o_res.zero = (i_sum == '0);
        o_res.neg  = i_sum[DATA_W-1];
        o_res.ovf  = (i_a_msb == i_b_msb) && (i_sum[DATA_W-1] != i_a_msb);
    end

endmodule : adder_flags

`default_nettype wire

// File: rtl/adder_result_stage.sv
// ============================================================================
// Module      : adder_result_stage
// Description : Registered result stage behind the adder: flag capture,
//               2-entry skid buffer, delivered-result counter, sticky carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_result_stage
    import adder_pkg::*;
#(
    parameter int N  = DATA_W,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          a_msb,
    input  logic          b_msb,
    input  logic [N-1:0]  sum,
    input  logic          cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_cout,
    output logic          out_zero,
    output logic          out_neg,
    output logic          out_ovf,
    output logic [CW-1:0] count,
    output logic          sticky_cout
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_in_ready;
    res_t          r_main;
    res_t          r_skid;
    res_t          w_res;
    logic [CW-1:0] r_count;
    logic          r_sticky;

    logic          w_accept;
    logic          w_xfer;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_main_from_skid;

    adder_flags u_flags (
        .i_sum   (sum),
        .i_cout  (cout),
        .i_a_msb (a_msb),
        .i_b_msb (b_msb),
        .o_res   (w_res)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = (r_state != EMPTY) && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_accept && w_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = BUSY;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
            r_count    <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered ready: the stage can take a result unless the skid is occupied.
            r_in_ready <= (w_state_nxt != FULL);
            if (w_load_main) begin
                r_main <= w_res;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_res;
            end
            if (clr) begin
                r_count <= '0;
            end else if (w_xfer) begin
                r_count <= r_count + 1'b1;
            end
            // A new carry event outranks a coincident clear.
            if (w_accept && cout) begin
                r_sticky <= 1'b1;
            end else if (clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != EMPTY);
    assign out_sum     = r_main.sum;
    assign out_cout    = r_main.cout;
    assign out_zero    = r_main.zero;
    assign out_neg     = r_main.neg;
    assign out_ovf     = r_main.ovf;
    assign count       = r_count;
    assign sticky_cout = r_sticky;

endmodule : adder_result_stage

`default_nettype wire

// File: tb/tb_adder_result_stage.sv
// ============================================================================
// Module      : tb_adder_result_stage
// Description : Directed self-checking bench for adder_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_result_stage;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic        a_msb;
    logic        b_msb;
    logic [7:0]  sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic        out_cout;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;
    logic [15:0] count;
    logic        sticky_cout;

    int checks = 0;
    int errors = 0;

    adder_result_stage #(.N(8), .CW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_msb       (a_msb),
        .b_msb       (b_msb),
        .sum         (sum),
        .cout        (cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_ovf     (out_ovf),
        .count       (count),
        .sticky_cout (sticky_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic c,
                         input logic am, input logic bm);
        in_valid = v;
        sum      = s;
        cout     = c;
        a_msb    = am;
        b_msb    = bm;
    endtask

    initial begin
        logic [8:0] sb[$];
        logic [8:0] exp_item;
        int         sent;
        int         got;
        int         cycles;
        logic       pending;

        rst = 1'b0; clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_flags", {out_cout, out_zero, out_neg, out_ovf}, 0);
        chk("rst_count", count, 0);
        chk("rst_sticky", sticky_cout, 0);
        rst = 1'b1;

        // First result: zero sum with carry.
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("first_valid", out_valid, 1);
        chk("first_sum", out_sum, 8'h00);
        chk("first_zero", out_zero, 1);
        chk("first_cout", out_cout, 1);
        chk("first_sticky", sticky_cout, 1);
        chk("first_count_pre", count, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("first_count", count, 1);
        chk("first_drained", out_valid, 0);

        // Signed overflow cases.
        drive(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("ovf_pos_flags", {out_zero, out_neg, out_ovf}, 3'b011);
        drive(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("ovf_neg_sum", out_sum, 8'h7F);
        chk("ovf_neg_flags", {out_zero, out_neg, out_ovf}, 3'b001);
        drive(1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("no_ovf_mixed", out_ovf, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("ovf_count", count, 4);

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_sticky", sticky_cout, 0);

        // Backpressure: 11 in main, 22 in skid, 33 held upstream.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("bp_ready_after1", in_ready, 1);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("bp_full_ready", in_ready, 0);
        drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("bp_hold_sum", out_sum, 8'h11);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_flags", {out_zero, out_neg, out_ovf}, 3'b000);
        out_ready = 1'b1;
        cyc();
        chk("bp_out2", out_sum, 8'h22);
        chk("bp_ready_back", in_ready, 1);
        cyc();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bp_out3", out_sum, 8'h33);
        cyc();
        chk("bp_count", count, 3);
        chk("bp_empty", out_valid, 0);

        // Random handshakes against a scoreboard.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        sent = 0; got = 0; cycles = 0; pending = 1'b0;
        while (got < 1000 && cycles < 20000) begin
            if (!pending) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0)
                    drive(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                else
                    in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                exp_item = (sb.size() > 0) ? sb.pop_front() : 9'bx;
                chk("rand_order", {23'd0, out_cout, out_sum}, {23'd0, exp_item});
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back({cout, sum});
                sent++;
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            cyc();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_delivered", got, 1000);
        chk("rand_count", count, 1000);

        // Counter wrap at 2^16-1.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (65535) cyc();
        in_valid = 1'b0;
        cyc();
        chk("wrap_preload", count, 16'hFFFF);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("wrap_zero", count, 0);

        // clr coincident with a transfer and a carry-carrying accept.
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("clr_pre_count", count, 1);
        chk("clr_pre_sticky", sticky_cout, 0);
        clr = 1'b1;
        drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        cyc();
        clr = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("clr_xfer_count", count, 0);
        chk("clr_accept_sticky", sticky_cout, 1);
        chk("clr_data_kept", out_sum, 8'h66);
        cyc();
        chk("clr_post_count", count, 1);

        // Reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("full_before_rst", in_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_sum", out_sum, 0);
        chk("async_rst_cnt_sticky", {count, sticky_cout}, 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        rst = 1'b1;
        cyc(); cyc();
        chk("no_stale_valid", out_valid, 0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_sum", out_sum, 8'h5A);
        chk("post_rst_valid", out_valid, 1);
        cyc();
        chk("post_rst_count", count, 1);
        chk("post_rst_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_result_stage

`default_nettype wire

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Registered output stage directly downstream of the N-bit `adder`.
- Captures each `sum`/`cout` result with its operand MSBs and derives status flags (zero, negative, signed overflow).
- Buffers results in a 2-entry skid buffer behind a valid/ready handshake.
- Keeps a delivered-result counter and a sticky carry flag for the consumer.

Parameters:
- N, 8, operand/sum width; must match the upstream adder `n`.
- CW, 16, width of the delivered-result counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of `count` and `sticky_cout`
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage can accept a result
- a_msb  input  1  bit N-1 of adder operand a
- b_msb  input  1  bit N-1 of adder operand b
- sum  input  N  adder sum
- cout  input  1  adder carry-out
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  N  registered sum
- out_cout  output  1  registered carry-out
- out_zero  output  1  out_sum == 0
- out_neg  output  1  out_sum[N-1]
- out_ovf  output  1  signed overflow of the add
- count  output  CW  results delivered since reset/clr
- sticky_cout  output  1  set on any accepted cout=1

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset values (rst=0), all immediate and asynchronous:
  - out_valid=0, in_ready=1, state=EMPTY.
  - out_sum=0, out_cout=0, out_zero=0, out_neg=0, out_ovf=0.
  - count=0, sticky_cout=0, skid entry invalid.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output transferred when out_valid & out_ready.
  - in_ready is a registered output, equal to !skid_full; it has no combinational path from out_ready.
- Flags, computed at capture and stored with the entry:
  - zero = (sum==0).
  - neg = sum[N-1].
  - ovf = (a_msb==b_msb) & (sum[N-1]!=a_msb).
  - Flags are held stable while out_valid=1 and out_ready=0.
- Latency: a result accepted at edge k appears on the outputs with out_valid=1 after edge k (1 cycle). Full throughput of 1 result per cycle while out_ready=1.
- State machine (main register + skid register):
  - EMPTY:
    - accept → load main, go to BUSY.
  - BUSY:
    - accept & transfer → load main, stay in BUSY.
    - accept & !transfer → load skid, go to FULL, in_ready=0.
    - transfer & !accept → go to EMPTY.
  - FULL (in_ready=0, no accept possible):
    - transfer → move skid into main, go to BUSY, in_ready=1.
- Ordering: results leave strictly in acceptance order. No drop and no duplication under any out_ready pattern.
- count:
  - +1 on each output transfer.
  - Wraps from 2^CW-1 to 0 with no flag.
- sticky_cout:
  - Set on any accepted input with cout=1.
  - Cleared only by clr or rst.
- clr behaviour:
  - Zeroes count and sticky_cout at the next edge. Does not affect buffered data or handshake state.
  - clr coincident with a transfer: count=0 (clr wins).
  - clr coincident with an accept carrying cout=1: sticky_cout=1 (new event wins).
- Reset mid-operation: buffered results are discarded and no partial output is produced. The first accept after rst deasserts behaves as from EMPTY.
- in_valid while in_ready=0: the input is ignored, and upstream must hold it.

Decomposition:
- adder_pkg holds:
  - state enum {EMPTY, BUSY, FULL}.
  - packed struct res_t {sum[N-1:0], cout, zero, neg, ovf} (parameterised via a localparam width).
- One combinational sub-module, adder_flags, maps (sum, cout, a_msb, b_msb) to res_t.
- The skid buffer and counter live in adder_result_stage.

Test Plan (N=8, CW=16):
- Reset release, out_ready=1: accept sum=8'h00, cout=1, a_msb=b_msb=0.
  - Next cycle: out_valid=1, out_sum=00, out_zero=1, out_cout=1, sticky_cout=1, then count=1.
- Signed overflow: sum=8'h80, a_msb=0, b_msb=0 → out_ovf=1, out_neg=1.
  - sum=8'h7F, a_msb=1, b_msb=1 → out_ovf=1, out_neg=0.
- Backpressure: out_ready=0, stream 8'h11, 8'h22, 8'h33 with in_valid=1.
  - 11 in main, 22 in skid, in_ready=0, 33 held upstream.
  - Release out_ready=1: outputs appear in order 11, 22, 33; count=3.
- Random out_ready/in_valid over 1000 results against a scoreboard → no loss or reorder.
  - Preload count=16'hFFFF, one transfer → count=0.
- clr with a coincident transfer and an accept carrying cout=1 → count=0, sticky_cout=1.
- rst asserted while FULL → outputs return immediately to reset values, in_ready=1, and no stale result emerges afterwards.
